// File: rtl/tapa_ctrl_fsm_n.sv
// Top-level controller for a task-parallel kernel: launches N_TASKS child tasks
// for a number of rounds, broadcasts latched scalars, and raises ap_done once.
module tapa_ctrl_fsm_n #(
  parameter int unsigned          N_TASKS     = 3,
  parameter int unsigned          SCALAR_W    = 64,
  parameter int unsigned          N_SCALARS   = 3,
  parameter logic [N_TASKS-1:0]   DETACH_MASK = '0,
  parameter int unsigned          DONE_DELAY  = 0
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            ap_start,
  output logic                            ap_ready,
  output logic                            ap_done,
  output logic                            ap_idle,
  input  logic [15:0]                     iter_count,
  input  logic [N_SCALARS*SCALAR_W-1:0]   scalars,
  output logic [N_SCALARS*SCALAR_W-1:0]   child_scalars,
  output logic [15:0]                     cur_iter,
  output logic [N_TASKS-1:0]              child_ap_start,
  input  logic [N_TASKS-1:0]              child_ap_ready,
  input  logic [N_TASKS-1:0]              child_ap_done,
  input  logic [N_TASKS-1:0]              child_ap_idle
);

  localparam int unsigned ITER_W  = 16;
  localparam int unsigned DRAIN_W = 8;

  typedef enum logic [2:0] {
    T_IDLE,
    T_RUN,
    T_GAP,
    T_DRAIN,
    T_DONE
  } top_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_START,
    C_WAIT,
    C_DONE
  } child_state_t;

  top_state_t          top_state;
  child_state_t        child_state [N_TASKS];
  logic [ITER_W-1:0]   iter_lat;
  logic [DRAIN_W-1:0]  drain_cnt;

  logic launch_c;
  logic round0_c;
  logic clear_c;
  logic all_done_c;
  logic more_rounds_c;

  // Child idle is observation-only; it never steers a transition.
  logic unused_child_idle;
  assign unused_child_idle = ^child_ap_idle;

  // Round completes when every attached task has reported done.
  always_comb begin
    all_done_c = 1'b1;
    for (int i = 0; i < int'(N_TASKS); i++) begin
      if (!DETACH_MASK[i] && (child_state[i] != C_DONE)) all_done_c = 1'b0;
    end
  end

  assign round0_c      = (top_state == T_IDLE);
  assign launch_c      = ((top_state == T_IDLE) && ap_start) || (top_state == T_GAP);
  assign clear_c       = (top_state == T_RUN) && all_done_c;
  assign more_rounds_c = ({1'b0, cur_iter} + 17'd1) < {1'b0, iter_lat};

  // Top-level sequencer: rounds, drain delay and the ap_done/ap_ready pulse.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      top_state     <= T_IDLE;
      ap_idle       <= 1'b1;
      ap_done       <= 1'b0;
      ap_ready      <= 1'b0;
      iter_lat      <= '0;
      cur_iter      <= '0;
      drain_cnt     <= '0;
      child_scalars <= '0;
    end else begin
      case (top_state)
        T_IDLE: begin
          if (ap_start) begin
            child_scalars <= scalars;
            iter_lat      <= (iter_count == '0) ? ITER_W'(1) : iter_count;
            cur_iter      <= '0;
            ap_idle       <= 1'b0;
            top_state     <= T_RUN;
          end
        end
        T_RUN: begin
          if (all_done_c) begin
            if (more_rounds_c) begin
              cur_iter  <= cur_iter + ITER_W'(1);
              top_state <= T_GAP;
            end else begin
              drain_cnt <= DRAIN_W'(DONE_DELAY);
              top_state <= T_DRAIN;
            end
          end
        end
        T_GAP: top_state <= T_RUN;
        T_DRAIN: begin
          if (drain_cnt == '0) begin
            ap_done   <= 1'b1;
            ap_ready  <= 1'b1;
            top_state <= T_DONE;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
        T_DONE: begin
          ap_done   <= 1'b0;
          ap_ready  <= 1'b0;
          ap_idle   <= 1'b1;
          top_state <= T_IDLE;
        end
        default: begin
          ap_done   <= 1'b0;
          ap_ready  <= 1'b0;
          ap_idle   <= 1'b1;
          top_state <= T_IDLE;
        end
      endcase
    end
  end

  // Per-task handshake; detached tasks are fire-and-forget after round 0.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      child_ap_start <= '0;
      for (int i = 0; i < int'(N_TASKS); i++) child_state[i] <= C_IDLE;
    end else begin
      for (int i = 0; i < int'(N_TASKS); i++) begin
        case (child_state[i])
          C_IDLE: begin
            if (launch_c && (!DETACH_MASK[i] || round0_c)) begin
              child_ap_start[i] <= 1'b1;
              child_state[i]    <= C_START;
            end
          end
          C_START: begin
            if (child_ap_ready[i]) begin
              child_ap_start[i] <= 1'b0;
              if (DETACH_MASK[i])        child_state[i] <= C_IDLE;
              else if (child_ap_done[i]) child_state[i] <= C_DONE;
              else                       child_state[i] <= C_WAIT;
            end
          end
          C_WAIT: begin
            if (child_ap_done[i]) child_state[i] <= C_DONE;
          end
          C_DONE: begin
            if (clear_c) child_state[i] <= C_IDLE;
          end
          default: begin
            child_ap_start[i] <= 1'b0;
            child_state[i]    <= C_IDLE;
          end
        endcase
      end
    end
  end

endmodule
